// File: rtl/if_mem_responder.sv
// Byte-serial fetch responder: turns one 32-bit fetch request into four sequential RAM byte reads.
// Optional word assembly output is enabled with `define IF_MEM_WORD_ASSEMBLE_EN.
module if_mem_responder #(
    parameter int RAM_AW    = 17,
    parameter int BYTES_PER = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_busy,
    output logic              fetch_valid,
    output logic [1:0]        fetch_idx,
    output logic [7:0]        fetch_byte,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_din
`ifdef IF_MEM_WORD_ASSEMBLE_EN
    ,
    output logic [31:0]       fetch_word,
    output logic              fetch_word_valid
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_base;
    logic [1:0]  r_idx;
    logic [31:0] w_sum;
    logic        w_unused;

    if (BYTES_PER != 4) begin : g_bytes_per_check
        $error("if_mem_responder: BYTES_PER must be 4");
    end

    // Address is formed at full 32-bit width; only the RAM-sized low bits leave the block.
    assign w_sum       = r_base + {30'd0, r_idx};
    assign w_unused    = ^w_sum[31:RAM_AW];
    assign ram_addr    = w_sum[RAM_AW-1:0];
    assign fetch_busy  = (r_state == S_READ);
    assign fetch_valid = (r_state == S_READ) && rdy_in;
    assign ram_rd      = fetch_valid;
    assign fetch_idx   = r_idx;
    assign fetch_byte  = ram_din;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (fetch_req) begin
                            r_base  <= fetch_addr;
                            r_idx   <= '0;
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        // The last byte doubles as the accept slot so back-to-back fetches have no bubble.
                        if (r_idx == 2'd3) begin
                            r_idx <= '0;
                            if (fetch_req) begin
                                r_base <= fetch_addr;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef IF_MEM_WORD_ASSEMBLE_EN
    logic        r_vld_p1;
    logic [1:0]  r_idx_p1;
    logic        r_word_vld_p2;
    logic [23:0] r_acc_p1;
    logic [31:0] r_word_p2;

    assign fetch_word       = r_word_p2;
    assign fetch_word_valid = r_word_vld_p2;

    // p1: RAM data for the byte issued last cycle; a flushed issue never contributes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_vld_p1      <= 1'b0;
            r_idx_p1      <= '0;
            r_word_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1      <= fetch_valid && !flush;
            r_idx_p1      <= r_idx;
            r_word_vld_p2 <= r_vld_p1 && (r_idx_p1 == 2'd3);
        end
    end

    // p2: little-endian word, held until the next complete word.
    always_ff @(posedge clk_in) begin
        if (r_vld_p1) begin
            case (r_idx_p1)
                2'd0:    r_acc_p1[7:0]   <= ram_din;
                2'd1:    r_acc_p1[15:8]  <= ram_din;
                2'd2:    r_acc_p1[23:16] <= ram_din;
                default: r_word_p2       <= {ram_din, r_acc_p1};
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_if_mem_responder.sv
// Self-checking bench for if_mem_responder: directed vector table plus randomized fetch traffic
// checked against a queue-based model of the expected byte-issue stream.
module tb_if_mem_responder;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_busy;
    logic        fetch_valid;
    logic [1:0]  fetch_idx;
    logic [7:0]  fetch_byte;
    logic [16:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_din;
`ifdef IF_MEM_WORD_ASSEMBLE_EN
    logic [31:0] fetch_word;
    logic        fetch_word_valid;
`endif

    if_mem_responder #(.RAM_AW(17), .BYTES_PER(4)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_busy (fetch_busy),
        .fetch_valid(fetch_valid),
        .fetch_idx  (fetch_idx),
        .fetch_byte (fetch_byte),
        .ram_addr   (ram_addr),
        .ram_rd     (ram_rd),
        .ram_din    (ram_din)
`ifdef IF_MEM_WORD_ASSEMBLE_EN
        ,
        .fetch_word      (fetch_word),
        .fetch_word_valid(fetch_word_valid)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] memf(input logic [16:0] a);
        if (a == 17'h100) return 8'h13;
        if (a >= 17'h101 && a <= 17'h103) return 8'h00;
        return a[7:0] ^ {a[15:9], a[16]} ^ 8'hA5;
    endfunction

    // Single-port RAM with one-cycle read latency
    always @(posedge clk_in) begin
        if (ram_rd) ram_din <= memf(ram_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    bit          prev_v = 1'b0;
    logic [16:0] prev_a = '0;
`ifdef IF_MEM_WORD_ASSEMBLE_EN
    bit          wv_d1 = 1'b0, wv_d2 = 1'b0;
    logic [31:0] w_d1 = '0, w_d2 = '0;
    logic [7:0]  wbytes [4];
`endif

    task automatic cyc(input bit req, input logic [31:0] addr, input bit fl, input bit rdy,
                       input bit ev, input logic [16:0] ea, input logic [1:0] ei, input bit eb,
                       input string nm);
        @(negedge clk_in);
        fetch_req  = req;
        fetch_addr = addr;
        flush      = fl;
        rdy_in     = rdy;
        #1;
        if (prev_v) chk({nm, ":fetch_byte"}, fetch_byte, memf(prev_a));
        chk({nm, ":fetch_valid"}, fetch_valid, ev);
        chk({nm, ":ram_rd"}, ram_rd, ev);
        chk({nm, ":fetch_busy"}, fetch_busy, eb);
        if (ev) begin
            chk({nm, ":ram_addr"}, ram_addr, ea);
            chk({nm, ":fetch_idx"}, fetch_idx, ei);
        end
`ifdef IF_MEM_WORD_ASSEMBLE_EN
        chk({nm, ":fetch_word_valid"}, fetch_word_valid, wv_d2);
        if (wv_d2) chk({nm, ":fetch_word"}, fetch_word, w_d2);
        if (ev && !fl) wbytes[ei] = memf(ea);
        wv_d2 = wv_d1;
        w_d2  = w_d1;
        wv_d1 = ev && !fl && (ei == 2'd3);
        w_d1  = {memf(ea), wbytes[2], wbytes[1], wbytes[0]};
`endif
        prev_v = ev;
        prev_a = ea;
    endtask

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          fl;
        bit          rdy;
        bit          ev;
        logic [16:0] ea;
        logic [1:0]  ei;
        bit          eb;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit req, input logic [31:0] addr, input bit fl, input bit rdy,
                     input bit ev, input logic [16:0] ea, input logic [1:0] ei, input bit eb,
                     input string nm);
        vec_t x;
        x.req = req; x.addr = addr; x.fl = fl; x.rdy = rdy;
        x.ev = ev; x.ea = ea; x.ei = ei; x.eb = eb; x.nm = nm;
        tbl.push_back(x);
    endtask

    typedef struct {
        logic [16:0] a;
        logic [1:0]  i;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] a_cur, a_nxt;
    bit          b2b_in, b2b_out, r, fr;
    int          rem, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        #7;
        chk("reset:fetch_busy", fetch_busy, 0);
        chk("reset:fetch_valid", fetch_valid, 0);
        chk("reset:ram_rd", ram_rd, 0);
        chk("reset:fetch_idx", fetch_idx, 0);
        chk("reset:ram_addr", ram_addr, 0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Single fetch at 0x100
        v(1, 32'h100, 0, 1, 0, 0, 0, 0, "f100_acc");
        for (int k = 0; k < 4; k++) v(0, 0, 0, 1, 1, 17'(32'h100 + k), 2'(k), 1, "f100_issue");
        v(0, 0, 0, 1, 0, 0, 0, 0, "f100_done");
        // Back-to-back 0x0 then 0x4
        v(1, 32'h0, 0, 1, 0, 0, 0, 0, "b2b_acc");
        for (int k = 0; k < 3; k++) v(0, 0, 0, 1, 1, 17'(k), 2'(k), 1, "b2b_w0");
        v(1, 32'h4, 0, 1, 1, 17'h3, 2'd3, 1, "b2b_last_acc");
        for (int k = 0; k < 4; k++) v(0, 0, 0, 1, 1, 17'(4 + k), 2'(k), 1, "b2b_w1");
        v(0, 0, 0, 1, 0, 0, 0, 0, "b2b_done");
        // Flush at idx 1 with a simultaneous request that must be ignored
        v(1, 32'h2000, 0, 1, 0, 0, 0, 0, "fl_acc");
        v(0, 0, 0, 1, 1, 17'h2000, 2'd0, 1, "fl_b0");
        v(1, 32'h3000, 1, 1, 1, 17'h2001, 2'd1, 1, "fl_b1");
        v(0, 0, 0, 1, 0, 0, 0, 0, "fl_idle");
        v(1, 32'h40, 0, 1, 0, 0, 0, 0, "fl_reacc");
        for (int k = 0; k < 4; k++) v(0, 0, 0, 1, 1, 17'(32'h40 + k), 2'(k), 1, "fl_new");
        v(0, 0, 0, 1, 0, 0, 0, 0, "fl_done");
        // Stall for three cycles at idx 2
        v(1, 32'h500, 0, 1, 0, 0, 0, 0, "st_acc");
        v(0, 0, 0, 1, 1, 17'h500, 2'd0, 1, "st_b0");
        v(0, 0, 0, 1, 1, 17'h501, 2'd1, 1, "st_b1");
        for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 0, 0, 0, 1, "st_stall");
        v(0, 0, 0, 1, 1, 17'h502, 2'd2, 1, "st_b2");
        v(0, 0, 0, 1, 1, 17'h503, 2'd3, 1, "st_b3");
        v(0, 0, 0, 1, 0, 0, 0, 0, "st_done");
        // RAM_AW wrap and 32-bit wrap
        v(1, 32'h0001FFFE, 0, 1, 0, 0, 0, 0, "wr_acc");
        v(0, 0, 0, 1, 1, 17'h1FFFE, 2'd0, 1, "wr_b0");
        v(0, 0, 0, 1, 1, 17'h1FFFF, 2'd1, 1, "wr_b1");
        v(0, 0, 0, 1, 1, 17'h00000, 2'd2, 1, "wr_b2");
        v(0, 0, 0, 1, 1, 17'h00001, 2'd3, 1, "wr_b3");
        v(0, 0, 0, 1, 0, 0, 0, 0, "wr_done");
        v(1, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, "w32_acc");
        v(0, 0, 0, 1, 1, 17'h1FFFF, 2'd0, 1, "w32_b0");
        v(0, 0, 0, 1, 1, 17'h00000, 2'd1, 1, "w32_b1");
        v(0, 0, 0, 1, 1, 17'h00001, 2'd2, 1, "w32_b2");
        v(0, 0, 0, 1, 1, 17'h00002, 2'd3, 1, "w32_b3");
        v(0, 0, 0, 1, 0, 0, 0, 0, "w32_done");
        v(0, 0, 0, 1, 0, 0, 0, 0, "w32_idle");

        for (int k = 0; k < tbl.size(); k++)
            cyc(tbl[k].req, tbl[k].addr, tbl[k].fl, tbl[k].rdy, tbl[k].ev, tbl[k].ea,
                tbl[k].ei, tbl[k].eb, tbl[k].nm);

        // Asynchronous reset in the middle of a fetch
        cyc(1, 32'h700, 0, 1, 0, 0, 0, 0, "rst_acc");
        cyc(0, 0, 0, 1, 1, 17'h700, 2'd0, 1, "rst_b0");
        cyc(0, 0, 0, 1, 1, 17'h701, 2'd1, 1, "rst_b1");
        #2;
        rst_in = 1'b0;
        #1;
        chk("midrst:fetch_busy", fetch_busy, 0);
        chk("midrst:fetch_valid", fetch_valid, 0);
        chk("midrst:ram_rd", ram_rd, 0);
        chk("midrst:fetch_idx", fetch_idx, 0);
        chk("midrst:ram_addr", ram_addr, 0);
        prev_v = 1'b0;
`ifdef IF_MEM_WORD_ASSEMBLE_EN
        wv_d1 = 1'b0;
        wv_d2 = 1'b0;
`endif
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc(0, 0, 0, 1, 0, 0, 0, 0, "post_rst0");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, "post_rst1");

        // Randomized traffic: the model is the queue of byte addresses each accepted request implies
        b2b_in = 1'b0;
        a_nxt  = $urandom;
        for (int t = 0; t < 40; t++) begin
            a_cur   = a_nxt;
            a_nxt   = $urandom;
            b2b_out = ($urandom % 3 == 0) && (t < 39);
            for (int k = 0; k < 4; k++) begin
                e.a = 17'(a_cur + 32'(k));
                e.i = 2'(k);
                exp_q.push_back(e);
            end
            if (!b2b_in) cyc(1, a_cur, 0, 1, 0, 0, 0, 0, "rnd_acc");
            rem = 4;
            while (rem > 0) begin
                r = ($urandom % 4) != 0;
                if (r) begin
                    e = exp_q.pop_front();
                    cyc((rem == 1) && b2b_out, a_nxt, 0, 1, 1, e.a, e.i, 1, "rnd_issue");
                    rem--;
                end else begin
                    cyc(0, 0, 0, 0, 0, 0, 0, 1, "rnd_stall");
                end
            end
            b2b_in = b2b_out;
            if (!b2b_out) begin
                n = $urandom % 3;
                for (int g = 0; g < n; g++) begin
                    fr = $urandom % 2;
                    cyc(fr, $urandom, fr, 1, 0, 0, 0, 0, "rnd_idle");
                end
            end
        end
        cyc(0, 0, 0, 1, 0, 0, 0, 0, "rnd_end0");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, "rnd_end1");
        chk("rnd:queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
